// File: rtl/adder_if.sv
// adder_if: operand/result bundle for the ripple adder.
//   master modport (driver side): drives a, b, c_in, in_valid; observes results.
//   slave  modport (adder side) : consumes operands, drives
//     sum/c_out/ovf (combinational) and sum_q/c_out_q/ovf_q/out_valid (registered).
// Parameter WIDTH (1..32) sets operand and sum width.
interface adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             out_valid;

  modport master (
    output a, b, c_in, in_valid,
    input  sum, c_out, ovf, sum_q, c_out_q, ovf_q, out_valid
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output sum, c_out, ovf, sum_q, c_out_q, ovf_q, out_valid
  );
endinterface

// File: rtl/adder.sv
// adder: WIDTH-bit ripple-carry adder with a one-cycle registered copy.
//   clk  : rising-edge clock for registered outputs
//   rst  : synchronous active-high reset (clears registered outputs only)
//   bus  : adder_if.slave
//     a, b, c_in, in_valid            -> operands and capture qualifier
//     sum, c_out, ovf                 <- combinational result
//     sum_q, c_out_q, ovf_q, out_valid <- result captured on in_valid
// Optional feature: define ADDER_OVF_EN to compute signed overflow; when
// undefined, ovf and ovf_q are tied low and no overflow logic exists.

// One full-adder bit of the ripple chain.
module adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module adder #(
  parameter int WIDTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  adder_if.slave bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_w;
  logic             ovf_w;
  // vld_pipe[0] is the incoming qualifier, vld_pipe[1] the registered flag.
  logic [1:0]       vld_pipe;

  assign carry[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    adder_fa u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (carry[i]),
      .s  (sum_w[i]),
      .co (carry[i+1])
    );
  end

`ifdef ADDER_OVF_EN
  // Carry into the sign bit differing from carry out of it means signed overflow.
  assign ovf_w = carry[WIDTH] ^ carry[WIDTH-1];
`else
  assign ovf_w = 1'b0;
`endif

  assign bus.sum   = sum_w;
  assign bus.c_out = carry[WIDTH];
  assign bus.ovf   = ovf_w;

  assign vld_pipe[0] = bus.in_valid;

  // Result registers hold when in_valid is low; reset beats a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum_q   <= '0;
      bus.c_out_q <= 1'b0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        bus.sum_q   <= sum_w;
        bus.c_out_q <= carry[WIDTH];
      end
    end
  end

`ifdef ADDER_OVF_EN
  logic ovf_r;
  always_ff @(posedge clk) begin
    if (rst)               ovf_r <= 1'b0;
    else if (vld_pipe[0])  ovf_r <= ovf_w;
  end
  assign bus.ovf_q = ovf_r;
`else
  assign bus.ovf_q = 1'b0;
`endif

  assign bus.out_valid = vld_pipe[1];

endmodule

// File: tb/tb_adder.sv
// tb_adder: directed and random checks of adder against an arithmetic model.
module tb_adder;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_if #(.WIDTH(W)) bus ();

  adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model of the registered outputs.
  logic [W-1:0] m_sum_q;
  logic         m_c_q;
  logic         m_ovf_q;
  logic         m_ov;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return (W+1)'(s);
  endfunction

  // Signed overflow: true result out of the W-bit two's-complement range.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
`ifdef ADDER_OVF_EN
    int sa, sb, s;
    sa = (int'(a) >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
    sb = (int'(b) >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
    s  = sa + sb + int'(c);
    return (s < -(2**(W-1))) || (s > 2**(W-1) - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational result, clock, then
  // check the registered result against the model.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic iv, input logic r);
    logic [W:0] e;
    logic       eo;
    bus.a = a; bus.b = b; bus.c_in = c; bus.in_valid = iv; rst = r;
    #1;
    e  = ref_add(a, b, c);
    eo = ref_ovf(a, b, c);
    chk("comb_sum", 32'({bus.c_out, bus.sum}), 32'(e));
    chk("comb_ovf", 32'(bus.ovf), 32'(eo));
    if (r) begin
      m_sum_q = '0; m_c_q = 1'b0; m_ovf_q = 1'b0; m_ov = 1'b0;
    end else if (iv) begin
      {m_c_q, m_sum_q} = e; m_ovf_q = eo; m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    @(posedge clk); #1;
    chk("reg_sum",   32'({bus.c_out_q, bus.sum_q}), 32'({m_c_q, m_sum_q}));
    chk("reg_ovf",   32'(bus.ovf_q), 32'(m_ovf_q));
    chk("reg_valid", 32'(bus.out_valid), 32'(m_ov));
    @(negedge clk);
  endtask

  initial begin
    logic ovf_en;
`ifdef ADDER_OVF_EN
    ovf_en = 1'b1;
`else
    ovf_en = 1'b0;
`endif
    m_sum_q = '0; m_c_q = 1'b0; m_ovf_q = 1'b0; m_ov = 1'b0;

    // Reset state.
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_sum_q", 32'(bus.sum_q), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);

    // Wrap-around corner vectors.
    step(4'hF, 4'h1, 1'b0, 1'b1, 1'b0);
    chk("f1_sum_q", 32'({bus.c_out_q, bus.sum_q}), 32'h10);
    step(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
    chk("ff1_sum_q", 32'({bus.c_out_q, bus.sum_q}), 32'h1F);
    step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Signed overflow vectors.
    step(4'h7, 4'h1, 1'b0, 1'b1, 1'b0);
    chk("71_ovf_q", 32'(bus.ovf_q), 32'(ovf_en));
    chk("71_sum_q", 32'(bus.sum_q), 32'h8);
    step(4'h8, 4'h8, 1'b0, 1'b1, 1'b0);
    chk("88_ovf_q", 32'(bus.ovf_q), 32'(ovf_en));
    chk("88_sum_q", 32'({bus.c_out_q, bus.sum_q}), 32'h10);

    // Capture then hold.
    step(4'h3, 4'h4, 1'b1, 1'b1, 1'b0);
    chk("cap_sum_q", 32'({bus.c_out_q, bus.sum_q}), 32'h08);
    chk("cap_valid", 32'(bus.out_valid), 32'h1);
    step(4'hA, 4'hB, 1'b1, 1'b0, 1'b0);
    chk("hold_sum_q", 32'(bus.sum_q), 32'h8);
    chk("hold_valid", 32'(bus.out_valid), 32'h0);

    // Reset wins over a simultaneous capture.
    step(4'h5, 4'h6, 1'b0, 1'b1, 1'b0);
    step(4'h9, 4'h6, 1'b1, 1'b1, 1'b1);
    chk("rstwin_sum_q", 32'(bus.sum_q), 32'h0);
    chk("rstwin_valid", 32'(bus.out_valid), 32'h0);
    step(4'h2, 4'h2, 1'b0, 1'b1, 1'b0);
    chk("post_rst_sum_q", 32'(bus.sum_q), 32'h4);

    // Back-to-back random captures.
    for (int i = 0; i < 1000; i++)
      step(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);

    // Mixed random traffic with holds and occasional resets.
    for (int i = 0; i < 300; i++)
      step(W'($urandom), W'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
